// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multiply/divide unit.
package mdu_pkg;

    localparam int unsigned MDU_MAX_W = 64;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_t;

    // Magnitude of a sign-extended operand; callers keep the low WIDTH bits.
    function automatic logic [MDU_MAX_W-1:0] abs_w(input logic [MDU_MAX_W-1:0] x,
                                                    input logic is_signed);
        return (is_signed && x[MDU_MAX_W-1]) ? -x : x;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between Execute and the multiply/divide unit.
interface mul_div_unit_if
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    mdu_op_t          op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, src_a, src_b, flush,
                    input  busy, done, div_by_zero, hi, lo);
    modport slave  (input  start, op, src_a, src_b, flush,
                    output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/mdu_div_core.sv
// Restoring radix-2 divider on magnitudes: one quotient bit per step.
module mdu_div_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last_c
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   partial_c;
    logic [WIDTH:0]   trial_c;

    // Bit WIDTH of the trial subtraction is the borrow: set means restore.
    always_comb begin
        partial_c = {remainder, quotient[WIDTH-1]};
        trial_c   = partial_c - {1'b0, dvs_q};
    end

    assign last_c = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            dvs_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (load) begin
            cnt_q     <= '0;
            dvs_q     <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else if (step) begin
            cnt_q <= cnt_q + CW'(1);
            if (!trial_c[WIDTH]) begin
                remainder <= trial_c[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b1};
            end else begin
                remainder <= partial_c[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Define MDU_FAST_MULT_EN for a single-cycle multiply array instead of shift-add.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] HILO_RESET = '0
) (
    input logic           clk,
    input logic           reset,
    mul_div_unit_if.slave bus
);
    localparam int unsigned W2 = 2 * WIDTH;

    mdu_state_t       state_q, state_d;
    logic             busy_q, done_q, dbz_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [W2-1:0]    prod_q;
    logic             neg_q, neg_rem_q, dz_q, is_div_q;
    logic             issue_mul_c, issue_div_c, write_hi_c, write_lo_c;
    logic             div_step_c, fix_c, mul_last_c, div_last_c, op_signed_c;
    logic [WIDTH-1:0] mag_a_c, mag_b_c, quo, rem;
    logic [W2-1:0]    prod_fix_c;
    logic [WIDTH-1:0] quo_fix_c, rem_fix_c;

    assign op_signed_c = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign mag_a_c = WIDTH'(abs_w(MDU_MAX_W'(signed'(bus.src_a)), op_signed_c));
    assign mag_b_c = WIDTH'(abs_w(MDU_MAX_W'(signed'(bus.src_b)), op_signed_c));

`ifdef MDU_FAST_MULT_EN
    localparam mdu_state_t MUL_ENTRY = ST_FIX;
    assign mul_last_c = 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)            prod_q <= '0;
        else if (issue_mul_c) prod_q <= W2'(mag_a_c) * W2'(mag_b_c);
    end
`else
    localparam mdu_state_t MUL_ENTRY = ST_MUL;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] mcand_q;
    logic [CW-1:0]    mul_cnt_q;
    logic [WIDTH:0]   mul_sum_c;

    // Multiplier sits in the low half of prod_q and is consumed LSB first.
    assign mul_sum_c  = {1'b0, prod_q[W2-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_last_c = (mul_cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q    <= '0;
            mcand_q   <= '0;
            mul_cnt_q <= '0;
        end else if (issue_mul_c) begin
            prod_q    <= {WIDTH'(0), mag_b_c};
            mcand_q   <= mag_a_c;
            mul_cnt_q <= '0;
        end else if (state_q == ST_MUL && !bus.flush) begin
            prod_q    <= {mul_sum_c, prod_q[WIDTH-1:1]};
            mul_cnt_q <= mul_cnt_q + CW'(1);
        end
    end
`endif

    mdu_div_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (issue_div_c),
        .step      (div_step_c),
        .dividend  (mag_a_c),
        .divisor   (mag_b_c),
        .quotient  (quo),
        .remainder (rem),
        .last_c    (div_last_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state and per-cycle strobes; flush beats every transition.
    always_comb begin
        state_d     = state_q;
        issue_mul_c = 1'b0;
        issue_div_c = 1'b0;
        write_hi_c  = 1'b0;
        write_lo_c  = 1'b0;
        div_step_c  = 1'b0;
        fix_c       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.flush) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin issue_mul_c = 1'b1; state_d = MUL_ENTRY; end
                        OP_DIV, OP_DIVU:   begin issue_div_c = 1'b1; state_d = ST_DIV; end
                        OP_MTHI:           write_hi_c = 1'b1;
                        OP_MTLO:           write_lo_c = 1'b1;
                        default:           ;
                    endcase
                end
            end
            ST_MUL: begin
                if (bus.flush)       state_d = ST_IDLE;
                else if (mul_last_c) state_d = ST_FIX;
            end
            ST_DIV: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    div_step_c = 1'b1;
                    if (div_last_c) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                fix_c   = !bus.flush;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            is_div_q  <= 1'b0;
        end else if (issue_mul_c || issue_div_c) begin
            neg_q     <= op_signed_c && (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
            neg_rem_q <= op_signed_c && bus.src_a[WIDTH-1];
            dz_q      <= (bus.src_b == '0);
            is_div_q  <= issue_div_c;
        end
    end

    // Divide-by-zero: remainder magnitude is |src_a|, so the sign fix restores src_a.
    assign prod_fix_c = neg_q ? -prod_q : prod_q;
    assign quo_fix_c  = dz_q ? '1 : (neg_q ? -quo : quo);
    assign rem_fix_c  = neg_rem_q ? -rem : rem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            hi_q   <= HILO_RESET;
            lo_q   <= HILO_RESET;
        end else begin
            busy_q <= (state_d != ST_IDLE);
            done_q <= fix_c;
            dbz_q  <= fix_c && is_div_q && dz_q;
            if (write_hi_c) hi_q <= bus.src_a;
            if (write_lo_c) lo_q <= bus.src_a;
            if (fix_c) begin
                if (is_div_q) begin
                    hi_q <= rem_fix_c;
                    lo_q <= quo_fix_c;
                end else begin
                    {hi_q, lo_q} <= prod_fix_c;
                end
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: random and directed ops against an arithmetic model.
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int unsigned W = 32;
    localparam logic [W-1:0] HR = 32'h0BAD_F00D;
`ifdef MDU_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mul_div_unit_if #(.WIDTH(W)) bus ();
    mul_div_unit #(.WIDTH(W), .HILO_RESET(HR)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    exp_t         sb_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] m_hi  = HR;
    logic [W-1:0] m_lo  = HR;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result of one op, from plain integer arithmetic.
    function automatic exp_t model(input mdu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t          e;
        longint        sa, sb, q, r;
        logic [2*W-1:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        e.hi = m_hi; e.lo = m_lo; e.dz = 1'b0;
        case (op)
            OP_MULT:  begin p = sa * sb; {e.hi, e.lo} = p; end
            OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; {e.hi, e.lo} = p; end
            OP_DIV, OP_DIVU: begin
                if (b == 0) begin
                    e.lo = '1; e.hi = a; e.dz = 1'b1;
                end else if (op == OP_DIV) begin
                    q = sa / sb; r = sa % sb;
                    e.lo = W'(q); e.hi = W'(r);
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
            OP_MTHI: e.hi = a;
            OP_MTLO: e.lo = a;
            default: ;
        endcase
        return e;
    endfunction

    // Monitor: every done pulse consumes one expected result.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset && (bus.done || bus.div_by_zero)) begin
            if (!bus.done) begin
                check("dz_without_done", 64'(bus.div_by_zero), 64'(0));
            end else if (sb_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                e = sb_q.pop_front();
                check("result_hi", 64'(bus.hi), 64'(e.hi));
                check("result_lo", 64'(bus.lo), 64'(e.lo));
                check("result_dz", 64'(bus.div_by_zero), 64'(e.dz));
            end
        end
    end

    task automatic issue(input mdu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic fl);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b; bus.flush = fl;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        bus.src_a = $urandom; bus.src_b = $urandom;
    endtask

    task automatic do_op(input mdu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   cyc;
        e = model(op, a, b);
        if (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) sb_q.push_back(e);
        issue(op, a, b, 1'b0);
        if (op inside {OP_MTHI, OP_MTLO}) begin
            m_hi = e.hi; m_lo = e.lo;
            check("mt_hi", 64'(bus.hi), 64'(m_hi));
            check("mt_lo", 64'(bus.lo), 64'(m_lo));
            check("mt_busy", 64'(bus.busy), 64'(0));
        end else if (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) begin
            cyc = 0;
            while (bus.busy === 1'b1 && cyc < 200) begin
                cyc++;
                @(negedge clk);
            end
            check("busy_cycles", 64'(cyc),
                  64'((op inside {OP_MULT, OP_MULTU}) ? MUL_LAT : W + 1));
            m_hi = e.hi; m_lo = e.lo;
        end
    endtask

    // Flush on the n-th busy cycle: engine idles next cycle, HI/LO untouched.
    task automatic flush_at(input mdu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int n);
        issue(op, a, b, 1'b0);
        for (int c = 1; c < n; c++) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'(0));
        check("flush_done", 64'(bus.done), 64'(0));
        check("flush_hi", 64'(bus.hi), 64'(m_hi));
        check("flush_lo", 64'(bus.lo), 64'(m_lo));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mdu_op_t      op;
        logic [W-1:0] a, b;
        bus.start = 1'b0; bus.op = OP_MULT; bus.src_a = '0; bus.src_b = '0; bus.flush = 1'b0;
        #1 reset = 1'b1;
        #12;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_dz", 64'(bus.div_by_zero), 64'(0));
        check("rst_hi", 64'(bus.hi), 64'(HR));
        check("rst_lo", 64'(bus.lo), 64'(HR));
        @(negedge clk) reset = 1'b0;

        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("tp_multu_hi", 64'(bus.hi), 64'(32'hFFFF_FFFE));
        check("tp_multu_lo", 64'(bus.lo), 64'(32'h0000_0001));
        do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("tp_div_lo", 64'(bus.lo), 64'(32'hFFFF_FFFD));
        do_op(OP_DIVU, 32'd100, 32'd0);
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("tp_ovf_lo", 64'(bus.lo), 64'(32'h8000_0000));

        flush_at(OP_DIV, 32'd1000, 32'd7, 10);
        do_op(OP_MTHI, 32'h1234_5678, 32'd0);
        flush_at(OP_DIV, 32'hFFFF_0000, 32'd3, W + 1);
        flush_at(OP_MULT, 32'h0000_1234, 32'hFFFF_FF00, MUL_LAT);
        do_op(OP_MTLO, 32'hCAFE_BABE, 32'd0);

        // flush beats a same-cycle MTHI
        issue(OP_MTHI, 32'h5555_AAAA, 32'd0, 1'b1);
        check("flush_mthi_hi", 64'(bus.hi), 64'(m_hi));
        check("flush_mthi_busy", 64'(bus.busy), 64'(0));

        // reset on the 5th busy cycle aborts with no done
        sb_q.push_back(model((MUL_LAT > 5) ? OP_MULT : OP_DIV, 32'd9, 32'd4));
        issue((MUL_LAT > 5) ? OP_MULT : OP_DIV, 32'd9, 32'd4, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        sb_q.delete();
        m_hi = HR; m_lo = HR;
        check("midrst_busy", 64'(bus.busy), 64'(0));
        check("midrst_done", 64'(bus.done), 64'(0));
        check("midrst_hi", 64'(bus.hi), 64'(HR));
        check("midrst_lo", 64'(bus.lo), 64'(HR));
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 60; i++) begin
            op = mdu_op_t'($urandom_range(0, 5));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : W'($urandom);
            case ($urandom_range(0, 9))
                0:       b = '0;
                1:       b = '1;
                2:       b = W'($urandom_range(1, 15));
                default: b = W'($urandom);
            endcase
            do_op(op, a, b);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers, sitting beside the Execute stage ALU.
- Replaces single-cycle HI/LO handling with a multi-cycle engine:
  - a busy/done handshake the pipeline stalls on;
  - a flush input so a mispredicted-path operation can be cancelled.
- Supports signed/unsigned multiply and divide, MTHI/MTLO writes, and WIDTH-generic operands.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits (even, >= 4).
- HILO_RESET, 0, value loaded into HI and LO on reset.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  issue strobe from Execute; sampled only when busy=0.
- op  input  3  operation code, mdu_op_t (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
- src_a  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- src_b  input  WIDTH  rt operand (divisor / multiplier).
- flush  input  1  cancel the in-flight operation.
- busy  output  1  engine occupied; pipeline must stall MFHI/MFLO/MDU ops.
- done  output  1  one-cycle pulse when HI/LO have been updated by MULT*/DIV*.
- div_by_zero  output  1  one-cycle pulse coincident with done for DIV/DIVU with src_b=0.
- hi  output  WIDTH  architectural HI register.
- lo  output  WIDTH  architectural LO register.

Behaviour:
- Reset (asynchronous):
  - state=IDLE; busy=0, done=0, div_by_zero=0;
  - hi=lo=HILO_RESET; iteration counter cleared.
  - Reset mid-operation aborts the operation with no done.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1, flush=0, at edge E0:
  - MULT/MULTU: operands latched (absolute values for signed ops, sign of result recorded), state->MUL.
  - DIV/DIVU: same latching, state->DIV.
  - MTHI/MTLO: hi (resp. lo) <= src_a at E0; state stays IDLE; no busy, no done.
- MUL: radix-2 shift-add, one multiplier bit per edge; WIDTH edges (E1..E_WIDTH); at E_WIDTH state->FIX.
- DIV: restoring radix-2, one quotient bit per edge; WIDTH edges; at E_WIDTH state->FIX.
- FIX, one edge E(WIDTH+1):
  - apply sign correction and write hi/lo;
  - state->IDLE; done=1 for the following cycle.
- busy=1 from after E0 to after E(WIDTH+1): exactly WIDTH+1 cycles.
- done is registered and asserted in the cycle after E(WIDTH+1).
- Multiply results:
  - {hi,lo} = full 2*WIDTH-bit product;
  - signed product = two's complement of the magnitude product when the operand signs differ.
- Divide results:
  - lo=quotient truncated toward zero;
  - hi=remainder, sign follows the dividend.
- Divide by zero (src_b=0): lo=all ones, hi=src_a; full latency still taken; div_by_zero pulses with done.
- Signed overflow (DIV, src_a=most negative, src_b=-1): lo=most negative, hi=0; no flag.
- start while busy=1: ignored, no queuing; the upstream stall guarantees this does not occur.
- flush=1 in MUL/DIV/FIX: state->IDLE at the next edge; hi/lo unchanged; no done.
- flush and start in the same IDLE cycle: flush wins, start ignored (including MTHI/MTLO).
- hi/lo are plain registers: MFHI/MFLO read them directly once busy=0.

Optional Feature:
- Macro: MDU_FAST_MULT_EN.
- Defined:
  - MULT/MULTU compute the full product combinationally at E0 and go straight to FIX;
  - busy for 1 cycle; done in the cycle after E1;
  - DIV latency unchanged.
- Undefined: iterative multiply as above; no multiplier array is inferred.

Decomposition:
- Package mdu_pkg holds:
  - the mdu_op_t enum (3-bit);
  - the mdu_state_t enum;
  - helper function abs_w for magnitude extraction.
- One sub-module, mdu_div_core: holds the restoring-divide datapath (remainder/quotient shift registers, counter), instantiated by mul_div_unit.
- Multiply path and FSM stay in the top module.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy 33 cycles, done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3 * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. With MDU_FAST_MULT_EN -> busy 1 cycle, same result.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1 with done.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, div_by_zero=0.
- Start DIV, flush on the 10th busy cycle -> busy=0 next cycle, hi/lo hold prior values, no done. Then MTHI 0x12345678 -> hi=0x12345678 after one edge, busy stays 0.
- Assert reset on the 5th busy cycle of MULT -> busy/done=0 immediately, hi=lo=HILO_RESET.
